// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the pipelined RV32I core.
//
// Owns the fetch PC, runs a single-outstanding req/ready handshake toward
// instruction memory and holds the IF/ID register (instruction, pc, valid)
// consumed by decode. A one-entry skid buffer catches a word that returns
// while decode is stalled, so no fetched word is ever lost or refetched.
//
// Optional feature (compile-time macro IF_BPRED_EN): static branch
// prediction on the word entering IF/ID. Backward conditional branches and
// jal are predicted taken and fetch continues at the computed target.
// Without the macro pred_taken_out is always 0 and fetch is sequential.
//
// Parameters:
//   RESET_PC        PC loaded on reset (word aligned)
//   NOP_INSTR       bubble placed on instr_out when valid_out is low
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   stall           decode cannot accept; IF/ID holds
//   redirect_valid  execute resolved a branch/jump; flush and refetch
//   redirect_pc     new fetch address, low two bits ignored
//   imem_req        fetch request (registered)
//   imem_addr       fetch address, held while a request is outstanding
//   imem_ready      imem_rdata valid; completes the current request
//   imem_rdata      fetched instruction word
//   instr_out       IF/ID instruction
//   pc_out          PC of instr_out
//   valid_out       instr_out is a real instruction
//   pred_taken_out  instr_out was predicted taken
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        pred_taken_out
);

    // state    | meaning
    // ---------+------------------------------------------------------------
    // ST_FETCH | request at pc_reg outstanding (or about to be issued)
    // ST_HOLD  | word parked in skid while decode stalls; no request
    // ST_DROP  | request to a pre-redirect address still in flight; its
    //          | data is thrown away, pc_reg already holds the new target
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_reg;
    logic [31:0] drop_addr;
    logic        req_q;
    logic [31:0] skid_instr;

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        pred_q;

    logic        handshake;
    logic [31:0] redirect_aligned;
    logic [31:0] load_word;
    logic [31:0] next_pc;
    logic        load_pred;

    assign handshake        = req_q && imem_ready;
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // The word entering IF/ID comes from the skid when leaving HOLD,
    // otherwise straight from memory. Both share the same pc_reg.
    assign load_word = (state == ST_HOLD) ? skid_instr : imem_rdata;

`ifdef IF_BPRED_EN
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic        is_bwd_branch;
    logic        is_jal;

    always_comb begin
        b_imm = {{20{load_word[31]}}, load_word[7], load_word[30:25],
                 load_word[11:8], 1'b0};
        j_imm = {{12{load_word[31]}}, load_word[19:12], load_word[20],
                 load_word[30:21], 1'b0};
        // Sign bit of the B immediate is instruction bit 31.
        is_bwd_branch = (load_word[6:2] == 5'b11000) && load_word[31];
        is_jal        = (load_word[6:2] == 5'b11011);
        load_pred     = is_bwd_branch || is_jal;
        // Targets are forced word aligned; a half-word target can only be
        // a mispredict that execute will correct with a redirect.
        if (is_jal) begin
            next_pc = (pc_reg + j_imm) & 32'hFFFF_FFFC;
        end else if (is_bwd_branch) begin
            next_pc = (pc_reg + b_imm) & 32'hFFFF_FFFC;
        end else begin
            next_pc = pc_reg + 32'd4;
        end
    end
`else
    assign load_pred = 1'b0;
    assign next_pc   = pc_reg + 32'd4;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc_reg     <= RESET_PC & 32'hFFFF_FFFC;
            drop_addr  <= 32'h0000_0000;
            req_q      <= 1'b0;
            skid_instr <= NOP_INSTR;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0000_0000;
            valid_q    <= 1'b0;
            pred_q     <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg     <= redirect_aligned;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            pred_q     <= 1'b0;
            skid_instr <= NOP_INSTR;
            req_q      <= 1'b1;
            if (req_q && !imem_ready) begin
                // A request is still in flight: keep presenting its address
                // until memory completes it. imem_addr is already the old
                // address in both FETCH and DROP, so capture it as is.
                state     <= ST_DROP;
                drop_addr <= imem_addr;
            end else begin
                state <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    req_q <= 1'b1;
                    if (handshake && stall) begin
                        skid_instr <= imem_rdata;
                        state      <= ST_HOLD;
                        req_q      <= 1'b0;
                    end else if (!stall) begin
                        if (handshake) begin
                            instr_q <= load_word;
                            pc_q    <= pc_reg;
                            valid_q <= 1'b1;
                            pred_q  <= load_pred;
                            pc_reg  <= next_pc;
                        end else begin
                            // Decode took the old entry and nothing replaces it.
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                            pred_q  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    req_q <= 1'b0;
                    if (!stall) begin
                        instr_q <= load_word;
                        pc_q    <= pc_reg;
                        valid_q <= 1'b1;
                        pred_q  <= load_pred;
                        pc_reg  <= next_pc;
                        state   <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_DROP: begin
                    // IF/ID was flushed on entry and stays a bubble here.
                    req_q <= 1'b1;
                    if (imem_ready) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = (state == ST_DROP) ? drop_addr : pc_reg;
    assign instr_out      = instr_q;
    assign pc_out         = pc_q;
    assign valid_out      = valid_q;
    assign pred_taken_out = pred_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// Testbench for if_stage. Directed vector table from reset, hand sequences
// for wait states / reset abort / prediction, then a randomized run checked
// against a program-order model of the expected instruction stream.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_BPRED_EN
    localparam bit BPRED = 1'b1;
`else
    localparam bit BPRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        pred_taken_out;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out),
        .pred_taken_out (pred_taken_out)
    );

    int tests = 0;
    int fails = 0;

    // memory model
    int          wcnt = 0;
    int          mem_wait = 0;
    logic        pre_req;
    logic        pre_rdy;
    logic [31:0] pre_addr;
    logic [31:0] fetch_log[$];
    logic [31:0] mem_over[logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return {a[26:2], 7'h13};
    endfunction

    // {predicted_taken, next_pc} for word w fetched at pc
    function automatic logic [32:0] ref_next(input logic [31:0] pc, input logic [31:0] w);
        int   b_off;
        int   j_off;
        logic bwd;
        logic jal;
        b_off = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
              - int'(w[31]) * 4096;
        j_off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
              - int'(w[31]) * 1048576;
        bwd = ((w & 32'h0000_007C) == 32'h0000_0060) && (b_off < 0);
        jal = ((w & 32'h0000_007C) == 32'h0000_006C);
        if (BPRED && jal) return {1'b1, (pc + j_off) & 32'hFFFF_FFFC};
        if (BPRED && bwd) return {1'b1, (pc + b_off) & 32'hFFFF_FFFC};
        return {1'b0, pc + 32'd4};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        logic rdy;
        rdy        = imem_req && (wcnt >= mem_wait);
        imem_ready = rdy;
        imem_rdata = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        pre_req    = imem_req;
        pre_addr   = imem_addr;
        pre_rdy    = rdy;
        @(posedge clk);
        #1;
        if (pre_req && rdy) begin
            fetch_log.push_back(pre_addr);
            wcnt = 0;
        end else if (pre_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        int          mwait;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input int w, input logic rq, input logic [31:0] ad,
                                input logic v, input logic [31:0] pc, input logic [31:0] ins);
        vec_t r;
        r.stall = st; r.redir = rd; r.rpc = rpc; r.mwait = w;
        r.e_req = rq; r.e_addr = ad; r.e_valid = v; r.e_pc = pc; r.e_instr = ins;
        return r;
    endfunction

    task automatic pred_case(input string name, input logic [31:0] w);
        logic [32:0] r;
        mem_over[32'h300] = w;
        stall = 1'b0; mem_wait = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        cycle();
        redirect_valid = 1'b0;
        chk({name, " redir addr"}, imem_addr, 32'h300);
        cycle();
        r = ref_next(32'h300, w);
        chk({name, " valid"}, 32'(valid_out), 32'd1);
        chk({name, " pc"}, pc_out, 32'h300);
        chk({name, " instr"}, instr_out, w);
        chk({name, " pred"}, 32'(pred_taken_out), 32'(r[32]));
        chk({name, " next addr"}, imem_addr, r[31:0]);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] p_instr;
    logic [31:0] p_pc;
    logic        p_valid;
    logic        p_pred;
    logic [32:0] nx;
    int          delivered;
    int          gap;
    int          max_gap;
    int          n104;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        mem_over[32'h100] = 32'h0050_0093;
        mem_over[32'h104] = 32'h0010_8113;
        @(negedge clk);
        cycle();
        cycle();

        // reset state
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst addr", imem_addr, 32'h100);
        chk("rst valid", 32'(valid_out), 32'd0);
        chk("rst instr", instr_out, NOP);
        chk("rst pc", pc_out, 32'h0);
        chk("rst pred", 32'(pred_taken_out), 32'd0);

        // two wait states on the first fetch
        rst = 1'b0; mem_wait = 2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("wait%0d req", i), 32'(imem_req), 32'd1);
            chk($sformatf("wait%0d addr", i), imem_addr, 32'h100);
            chk($sformatf("wait%0d valid", i), 32'(valid_out), 32'd0);
        end
        cycle();
        chk("wait cap valid", 32'(valid_out), 32'd1);
        chk("wait cap pc", pc_out, 32'h100);
        chk("wait cap instr", instr_out, 32'h0050_0093);
        chk("wait cap addr", imem_addr, 32'h104);

        // reset while the 0x104 request is outstanding
        rst = 1'b1;
        cycle();
        chk("rst abort req", 32'(imem_req), 32'd0);
        chk("rst abort valid", 32'(valid_out), 32'd0);
        chk("rst abort pc", pc_out, 32'h0);
        cycle();
        rst = 1'b0; mem_wait = 0;
        fetch_log.delete();

        // directed table
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h100, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h104, 1'b1, 32'h100, 32'h0050_0093));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h104, 1'b1, 32'h100, 32'h0050_0093));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h104, 1'b1, 32'h100, 32'h0050_0093));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h104, 1'b1, 32'h100, 32'h0050_0093));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h108, 1'b1, 32'h104, 32'h0010_8113));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 3, 1'b1, 32'h108, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b0, 1'b1, 32'h203, 3, 1'b1, 32'h108, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 3, 1'b1, 32'h108, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 3, 1'b1, 32'h200, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h204, 1'b1, 32'h200, mem_word(32'h200)));
        vecs.push_back(mk(1'b1, 1'b1, 32'h400, 0, 1'b1, 32'h400, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h400, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b1, 1'b1, 32'h500, 0, 1'b1, 32'h500, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h504, 1'b1, 32'h500, mem_word(32'h500)));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h508, 1'b1, 32'h504, mem_word(32'h504)));
        vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFE, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h4, 1'b1, 32'h0, mem_word(32'h0)));

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            mem_wait = vecs[i].mwait;
            cycle();
            chk($sformatf("vec%0d req", i), 32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d valid", i), 32'(valid_out), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d instr", i), instr_out, vecs[i].e_instr);
            if (vecs[i].e_valid) chk($sformatf("vec%0d pc", i), pc_out, vecs[i].e_pc);
        end
        redirect_valid = 1'b0; stall = 1'b0;

        n104 = 0;
        foreach (fetch_log[k]) if (fetch_log[k] == 32'h104) n104++;
        chk("single fetch of 0x104", n104, 1);

        // prediction cases (sequential expectations without the feature)
        pred_case("bwd beq", 32'hFE00_0EE3);
        pred_case("fwd beq", 32'h0000_0463);
        pred_case("jal", 32'h0100_006F);

        // randomized run against the stream model
        stall = 1'b0; mem_wait = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h1000;
        cycle();
        exp_pc = 32'h1000;
        redirect_valid = 1'b0;
        delivered = 0; gap = 0; max_gap = 0;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 5);
            redirect_pc = 32'h1000 + $urandom_range(0, 4095);
            mem_wait = int'($urandom_range(0, 2));
            p_valid = valid_out; p_instr = instr_out; p_pc = pc_out; p_pred = pred_taken_out;
            cycle();
            gap++;
            if (redirect_valid) begin
                chk("rnd flush valid", 32'(valid_out), 32'd0);
                chk("rnd flush instr", instr_out, NOP);
                chk("rnd flush pred", 32'(pred_taken_out), 32'd0);
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (stall) begin
                chk("rnd hold valid", 32'(valid_out), 32'(p_valid));
                chk("rnd hold instr", instr_out, p_instr);
                chk("rnd hold pc", pc_out, p_pc);
                chk("rnd hold pred", 32'(pred_taken_out), 32'(p_pred));
            end else if (valid_out) begin
                nx = ref_next(exp_pc, mem_word(exp_pc));
                chk("rnd pc", pc_out, exp_pc);
                chk("rnd instr", instr_out, mem_word(exp_pc));
                chk("rnd pred", 32'(pred_taken_out), 32'(nx[32]));
                exp_pc = nx[31:0];
                delivered++;
                gap = 0;
            end else begin
                chk("rnd bubble instr", instr_out, NOP);
            end
            if (gap > max_gap) max_gap = gap;
            if (pre_req && !pre_rdy) begin
                chk("rnd req held", 32'(imem_req), 32'd1);
                chk("rnd addr held", imem_addr, pre_addr);
            end
        end
        redirect_valid = 1'b0; stall = 1'b0;
        chk("rnd deliveries", 32'(delivered >= 200), 32'd1);
        chk("rnd max gap", 32'(max_gap <= 40), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
